// File: rtl/ones_comp_checksum_rx_pkg.sv
// Shared definitions for the 8-bit ones'-complement checksum framing.
// Both the receive checker and the future transmit generator use this package.
package ones_comp_pkg;

   // Widest word the shared helpers support.
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } state_e;

   // All-ones mask of width w, zero-extended to MAX_W bits.
   function automatic logic [MAX_W-1:0] all_ones(input int w);
      logic [MAX_W-1:0] m;
      if (w >= MAX_W) m = '1;
      else            m = (MAX_W'(1) << w) - MAX_W'(1);
      return m;
   endfunction

   // w-bit ones'-complement add: form the w+1-bit sum, then add the carry back in.
   // The second add cannot carry out, because a carry-out implies the low part is at most 2^w - 2.
   function automatic logic [MAX_W-1:0] fold(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int               w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W:0]   s;
      logic             carry;
      mask  = all_ones(w);
      s     = {1'b0, a & mask} + {1'b0, b & mask};
      carry = |((s >> w) & {{MAX_W{1'b0}}, 1'b1});
      return ((s[MAX_W-1:0] & mask) + {{(MAX_W-1){1'b0}}, carry}) & mask;
   endfunction

endpackage

// File: rtl/ones_comp_checksum_rx_if.sv
// Stream-in / result-out handshake bundle for the ones'-complement checker.
// The slave view is the checker; the master view is the deframer plus consumer.
interface ones_comp_checksum_rx_if #(
   parameter int W       = 8,
   parameter int MAX_LEN = 16
);
   localparam int LW = $clog2(MAX_LEN + 1);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_last;
   logic          res_valid;
   logic          res_ready;
   logic          res_ok;
   logic [W-1:0]  res_sum;
   logic [LW-1:0] res_len;
   logic          res_overflow;

   modport slave (
      input  in_valid, in_data, in_last, res_ready,
      output in_ready, res_valid, res_ok, res_sum, res_len, res_overflow
   );

   modport master (
      output in_valid, in_data, in_last, res_ready,
      input  in_ready, res_valid, res_ok, res_sum, res_len, res_overflow
   );
endinterface

// File: rtl/ones_comp_checksum_rx_adder.sv
// W-bit end-around-carry adder, purely combinational.
// Shared with the transmit-side checksum generator.
module ones_comp_adder
   import ones_comp_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum
);

   assign o_sum = W'(fold(MAX_W'(i_a), MAX_W'(i_b), W));

endmodule

// File: rtl/ones_comp_checksum_rx.sv
// Receive-side ones'-complement checksum checker.
// Folds every word of a frame (checksum word included) and holds pass/fail,
// the final sum and the word count until the consumer takes them.
module ones_comp_checksum_rx
   import ones_comp_pkg::*;
#(
   parameter int W       = 8,
   parameter int MAX_LEN = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ones_comp_checksum_rx_if.slave bus
);

   localparam int            LW       = $clog2(MAX_LEN + 1);
   localparam logic [W-1:0]  ALL_ONES = W'(all_ones(W));
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

   state_e        r_state;
   logic [W-1:0]  r_acc;
   logic [LW-1:0] r_len;
   logic          r_ovf;

   logic          w_beat;
   logic [W-1:0]  w_add_a;
   logic [W-1:0]  w_sum;

   // Words are only taken outside RESULT; in_last is meaningful only on a beat.
   assign w_beat  = bus.in_valid && (r_state != RESULT);
   // A new frame always starts from a zero accumulator.
   assign w_add_a = (r_state == IDLE) ? '0 : r_acc;

   ones_comp_adder #(.W(W)) u_adder (
      .i_a   (w_add_a),
      .i_b   (bus.in_data),
      .o_sum (w_sum)
   );

   // Frame FSM with accumulator, saturating length counter and overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_len   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_beat) begin
                  r_acc   <= w_sum;
                  r_len   <= LW'(1);
                  r_ovf   <= 1'b0;
                  r_state <= bus.in_last ? RESULT : ACCUM;
               end
            end
            ACCUM: begin
               if (w_beat) begin
                  r_acc <= w_sum;
                  // Extra words are still folded in but only flag overflow.
                  if (r_len == LEN_MAX) r_ovf <= 1'b1;
                  else                  r_len <= r_len + LW'(1);
                  if (bus.in_last) r_state <= RESULT;
               end
            end
            RESULT: begin
               if (bus.res_ready) begin
                  r_acc   <= '0;
                  r_len   <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Outputs come straight from registers, so they are stable while res_valid is held.
   // Only all-ones passes; all-zero is never produced by a valid transmitter.
   assign bus.in_ready     = (r_state != RESULT);
   assign bus.res_valid    = (r_state == RESULT);
   assign bus.res_sum      = r_acc;
   assign bus.res_len      = r_len;
   assign bus.res_overflow = r_ovf;
   assign bus.res_ok       = (r_acc == ALL_ONES) && !r_ovf;

endmodule
